// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter.
// FSM encodings and the per-port control-field width.
package dmem_arbiter_pkg;

  localparam int CTRL_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Rotating-priority request picker, purely combinational.
// Search starts at base+1 and wraps; the nearest requester wins.
module dmem_arbiter_rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] base,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  // Walk the ring farthest-first so the nearest requester is written last.
  always_comb begin
    int p;
    p     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      p = (int'(base) + k) % N;
      if (req[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        idx    = IW'(p);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// N-port arbiter in front of the unified memory data port.
// One transaction at a time: IDLE picks, MEM waits, RESP pulses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORTS-1:0]           m_wr_en,
  input  logic [N_PORTS-1:0]           m_rd_en,
  input  logic [CTRL_W*N_PORTS-1:0]    m_ctrl,
  input  logic [ADDR_W*N_PORTS-1:0]    m_addr,
  input  logic [DATA_W*N_PORTS-1:0]    m_wr_data,
  output logic [DATA_W*N_PORTS-1:0]    m_rd_data,
  output logic [N_PORTS-1:0]           m_available,
  output logic                         s_wr_en,
  output logic                         s_rd_en,
  output logic [CTRL_W-1:0]            s_ctrl,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wr_data,
  input  logic [DATA_W-1:0]            s_rd_data,
  input  logic                         s_available,
  output logic                         busy,
  output logic [$clog2(N_PORTS)-1:0]   grant_id
);

  localparam int IW = $clog2(N_PORTS);

  logic [1:0]         state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      base;
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] win_gnt;
  logic [IW-1:0]      win_idx;
  logic               win_valid;

  assign req = m_wr_en | m_rd_en;

  // Fixed priority is the rotating search pinned to start at port 0.
  assign base = (RR_MODE != 0) ? last_grant : IW'(N_PORTS - 1);

  dmem_arbiter_rr_picker #(
    .N(N_PORTS)
  ) u_picker (
    .req  (req),
    .base (base),
    .gnt  (win_gnt),
    .idx  (win_idx),
    .valid(win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= IW'(N_PORTS - 1);
      grant_id    <= '0;
      busy        <= 1'b0;
      s_wr_en     <= 1'b0;
      s_rd_en     <= 1'b0;
      s_ctrl      <= '0;
      s_addr      <= '0;
      s_wr_data   <= '0;
      m_rd_data   <= '0;
      m_available <= '0;
    end else begin
      m_available <= '0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            s_wr_en    <= |(win_gnt & m_wr_en);
            s_rd_en    <= |(win_gnt & m_rd_en & ~m_wr_en);
            s_ctrl     <= m_ctrl[win_idx*CTRL_W +: CTRL_W];
            s_addr     <= m_addr[win_idx*ADDR_W +: ADDR_W];
            s_wr_data  <= m_wr_data[win_idx*DATA_W +: DATA_W];
            grant_id   <= win_idx;
            last_grant <= win_idx;
            busy       <= 1'b1;
            state      <= ST_MEM;
          end
        end
        ST_MEM: begin
          if (s_available) begin
            if (s_rd_en) begin
              m_rd_data[grant_id*DATA_W +: DATA_W] <= s_rd_data;
            end
            m_available[grant_id] <= 1'b1;
            s_wr_en <= 1'b0;
            s_rd_en <= 1'b0;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          s_wr_en <= 1'b0;
          s_rd_en <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench: lane 0 is a 4-port round-robin arbiter, lane 1 fixed priority.
// A cycle model per lane is compared on every negedge; directed tests add literals.
module tb_dmem_arbiter;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst;

  logic [NP-1:0]    m_wr_en     [2];
  logic [NP-1:0]    m_rd_en     [2];
  logic [4*NP-1:0]  m_ctrl      [2];
  logic [32*NP-1:0] m_addr      [2];
  logic [32*NP-1:0] m_wr_data   [2];
  logic [32*NP-1:0] m_rd_data   [2];
  logic [NP-1:0]    m_available [2];
  logic             s_wr_en     [2];
  logic             s_rd_en     [2];
  logic [3:0]       s_ctrl      [2];
  logic [31:0]      s_addr      [2];
  logic [31:0]      s_wr_data   [2];
  logic [31:0]      s_rd_data   [2];
  logic             s_available [2];
  logic             mem_av      [2];
  logic             spur        [2];
  logic             busy        [2];
  logic [1:0]       grant_id    [2];

  logic [31:0] mem [2][256];
  int lat [2];
  int cnt [2];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dlog [2][64];
  int dcnt [2];
  int avcnt [2][NP];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Winner = first requester met when walking forward from base+1.
  function automatic int pick(input logic [NP-1:0] req, input int base);
    int p;
    pick = -1;
    for (int k = 1; k <= NP; k++) begin
      p = (base + k) % NP;
      if (pick < 0 && req[p]) pick = p;
    end
  endfunction

  task automatic wait_av(input int g, input int p);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_available[g][p]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_av lane%0d port%0d: got timeout expected pulse", g, p);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    assign s_available[g] = mem_av[g] | spur[g];

    dmem_arbiter #(
      .N_PORTS(NP),
      .ADDR_W (32),
      .DATA_W (32),
      .RR_MODE(g == 0 ? 1 : 0)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .m_wr_en    (m_wr_en[g]),
      .m_rd_en    (m_rd_en[g]),
      .m_ctrl     (m_ctrl[g]),
      .m_addr     (m_addr[g]),
      .m_wr_data  (m_wr_data[g]),
      .m_rd_data  (m_rd_data[g]),
      .m_available(m_available[g]),
      .s_wr_en    (s_wr_en[g]),
      .s_rd_en    (s_rd_en[g]),
      .s_ctrl     (s_ctrl[g]),
      .s_addr     (s_addr[g]),
      .s_wr_data  (s_wr_data[g]),
      .s_rd_data  (s_rd_data[g]),
      .s_available(s_available[g]),
      .busy       (busy[g]),
      .grant_id   (grant_id[g])
    );

    // Memory: answers lat[g] cycles after the request first appears.
    always @(negedge clk) begin
      if (s_wr_en[g] || s_rd_en[g]) begin
        if (cnt[g] == lat[g]) begin
          mem_av[g] = 1'b1;
          if (s_wr_en[g]) mem[g][s_addr[g][9:2]] = s_wr_data[g];
          else s_rd_data[g] = mem[g][s_addr[g][9:2]];
        end else begin
          mem_av[g] = 1'b0;
        end
        cnt[g] = cnt[g] + 1;
      end else begin
        mem_av[g] = 1'b0;
        cnt[g] = 0;
      end
    end

    int owner;
    bit done;
    bit is_rd;
    int lastg;
    int win;
    logic ew, er, ebusy;
    logic [3:0] ectrl;
    logic [31:0] eaddr, ewd;
    logic [NP-1:0] eav;
    logic [32*NP-1:0] erd;
    logic [1:0] egid;
    bit pbusy = 1'b0;

    always_comb win = pick(m_wr_en[g] | m_rd_en[g], (g == 0) ? lastg : NP - 1);

    // Model: owner<0 means free; done marks the response cycle.
    always @(posedge clk) begin
      if (rst) begin
        owner <= -1; done <= 1'b0; is_rd <= 1'b0; lastg <= NP - 1;
        ew <= 1'b0; er <= 1'b0; ectrl <= '0; eaddr <= '0; ewd <= '0;
        eav <= '0; erd <= '0; ebusy <= 1'b0; egid <= '0;
      end else if (owner < 0) begin
        eav <= '0;
        if (win >= 0) begin
          owner <= win;
          lastg <= win;
          egid  <= 2'(win);
          ebusy <= 1'b1;
          ew    <= m_wr_en[g][win];
          er    <= !m_wr_en[g][win];
          is_rd <= !m_wr_en[g][win];
          ectrl <= m_ctrl[g][win*4 +: 4];
          eaddr <= m_addr[g][win*32 +: 32];
          ewd   <= m_wr_data[g][win*32 +: 32];
        end
      end else if (!done) begin
        if (s_available[g]) begin
          done <= 1'b1;
          ew <= 1'b0;
          er <= 1'b0;
          eav[owner] <= 1'b1;
          if (is_rd) erd[owner*32 +: 32] <= s_rd_data[g];
        end
      end else begin
        eav <= '0;
        owner <= -1;
        done <= 1'b0;
        ebusy <= 1'b0;
      end
    end

    always @(negedge clk) begin
      check($sformatf("s_bus%0d", g),
            {s_wr_en[g], s_rd_en[g], s_ctrl[g], s_addr[g], s_wr_data[g]},
            {ew, er, ectrl, eaddr, ewd});
      check($sformatf("m_available%0d", g), m_available[g], eav);
      check($sformatf("m_rd_data%0d", g), m_rd_data[g], erd);
      check($sformatf("busy%0d", g), busy[g], ebusy);
      check($sformatf("grant_id%0d", g), grant_id[g], egid);
      for (int p = 0; p < NP; p++)
        if (m_available[g][p]) avcnt[g][p]++;
      if (busy[g] && !pbusy) begin
        if (dcnt[g] < 64) dlog[g][dcnt[g]] = int'(grant_id[g]);
        dcnt[g]++;
      end
      pbusy = busy[g];
    end
  end

  initial begin
    int c0, b, n2;
    int seq [5];
    int av0 [NP];
    seq = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      m_wr_en[g] = '0; m_rd_en[g] = '0; m_ctrl[g] = '0;
      m_addr[g] = '0; m_wr_data[g] = '0; spur[g] = 1'b0;
      mem_av[g] = 1'b0; s_rd_data[g] = '0; lat[g] = 1; cnt[g] = 0;
      dcnt[g] = 0;
      for (int p = 0; p < NP; p++) avcnt[g][p] = 0;
      for (int i = 0; i < 256; i++) mem[g][i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_gid", grant_id[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_rd_data", m_rd_data[0], 0);
    check("rst_s_rd_en", s_rd_en[0], 0);
    rst = 1'b0;

    // Single read, 1-cycle memory: m_available three cycles after edge 0.
    mem[0][8'h40] = 32'hdeadbeef;
    c0 = cyc;
    m_addr[0][63:32] = 32'h100;
    m_rd_en[0][1] = 1'b1;
    @(negedge clk);
    check("rd_s_rd_en_c1", s_rd_en[0], 1);
    check("rd_s_addr_c1", s_addr[0], 32'h100);
    wait_av(0, 1);
    check("rd_latency", cyc - c0, 3);
    check("rd_data", m_rd_data[0][63:32], 32'hdeadbeef);
    m_rd_en[0][1] = 1'b0;

    // Write then read back on port 0.
    m_addr[0][31:0] = 32'h40;
    m_wr_data[0][31:0] = 32'h12345678;
    m_ctrl[0][3:0] = 4'hf;
    m_wr_en[0][0] = 1'b1;
    wait_av(0, 0);
    check("wr_keeps_rd_data", m_rd_data[0][31:0], 0);
    check("wr_mem", mem[0][16], 32'h12345678);
    m_wr_en[0][0] = 1'b0;
    m_rd_en[0][0] = 1'b1;
    wait_av(0, 0);
    check("rd_back", m_rd_data[0][31:0], 32'h12345678);
    m_rd_en[0][0] = 1'b0;

    // wr_en and rd_en together act as a write.
    m_addr[0][127:96] = 32'h80;
    m_wr_data[0][127:96] = 32'hcafef00d;
    m_wr_en[0][3] = 1'b1;
    m_rd_en[0][3] = 1'b1;
    wait_av(0, 3);
    check("wr_rd_no_return", m_rd_data[0][127:96], 0);
    check("wr_rd_mem", mem[0][32], 32'hcafef00d);
    m_wr_en[0][3] = 1'b0;
    m_rd_en[0][3] = 1'b0;

    // Spurious s_available while idle.
    @(negedge clk);
    spur[0] = 1'b1;
    @(negedge clk);
    spur[0] = 1'b0;
    check("spur_av", m_available[0], 0);
    check("spur_busy", busy[0], 0);
    @(negedge clk);
    check("spur_av2", m_available[0], 0);

    // Round-robin contention from a fresh reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lat[0] = 0;
    for (int p = 0; p < NP; p++) begin
      mem[0][8'h80 + p] = 32'ha0 + p;
      m_addr[0][p*32 +: 32] = 32'h200 + 4 * p;
      av0[p] = avcnt[0][p];
    end
    b = dcnt[0];
    m_rd_en[0] = 4'hf;
    for (int i = 0; i < 100 && dcnt[0] < b + 5; i++) begin
      @(negedge clk);
      #1;
    end
    m_rd_en[0] = '0;
    wait_av(0, 0);
    #1;
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_seq%0d", i), dlog[0][b + i], seq[i]);
    check("rr_av_p0", avcnt[0][0] - av0[0], 2);
    for (int p = 1; p < NP; p++)
      check($sformatf("rr_av_p%0d", p), avcnt[0][p] - av0[p], 1);
    check("rr_p3_data", m_rd_data[0][127:96], 32'ha3);

    // Fixed priority: port 0 keeps re-requesting, port 2 starves.
    lat[1] = 0;
    mem[1][8'h40] = 32'h11110000;
    mem[1][8'h90] = 32'h22220000;
    m_addr[1][31:0] = 32'h100;
    m_addr[1][95:64] = 32'h240;
    b = dcnt[1];
    m_rd_en[1] = 4'b0101;
    repeat (24) @(negedge clk);
    #1;
    n2 = 0;
    for (int i = b; i < dcnt[1] && i < 64; i++)
      if (dlog[1][i] == 2) n2++;
    check("fp_port2_starved", n2, 0);
    check("fp_grant_count", dcnt[1] - b, 8);
    check("fp_p0_data", m_rd_data[1][31:0], 32'h11110000);
    m_rd_en[1] = 4'b0100;
    wait_av(1, 2);
    check("fp_p2_gid", grant_id[1], 2);
    check("fp_p2_data", m_rd_data[1][95:64], 32'h22220000);
    m_rd_en[1] = '0;

    // Reset while the memory stalls.
    @(negedge clk);
    lat[0] = 5;
    m_addr[0][95:64] = 32'h208;
    m_rd_en[0] = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("stall_busy", busy[0], 1);
    check("stall_gid", grant_id[0], 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_s_rd_en", s_rd_en[0], 0);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_av", m_available[0], 0);
    rst = 1'b0;
    m_addr[0][31:0] = 32'h200;
    m_rd_en[0] = 4'b0101;
    @(negedge clk);
    check("post_rst_gid", grant_id[0], 0);
    check("post_rst_addr", s_addr[0], 32'h200);
    wait_av(0, 0);
    check("post_rst_data", m_rd_data[0][31:0], 32'ha0);
    m_rd_en[0] = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
